keyscan: RTL and testbench

KEYSCAN -- requirements
Module: keyscan

---
 rtl/keyscan.sv | 127 ++++++++++++
 tb/tb_keyscan.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/keyscan.sv
// keyscan: 4x4 active-low keypad scanner with frame-based debounce.
// Drives one column low at a time for SCAN_DIV cycles and samples the rows
// on the last cycle. It builds a 16-bit frame per sweep and publishes it on
// keys after DEBOUNCE identical consecutive frames.
// Optional macro KEYSCAN_SYNC_EN adds a 2-flop row synchronizer. The
// synchronizer adds two cycles of input latency.
module keyscan #(
  parameter int SCAN_DIV = 4,
  parameter int DEBOUNCE = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        scan_en,
  input  logic [3:0]  row_in,
  output logic [3:0]  col_out,
  output logic [15:0] keys,
  output logic        changed
);

  localparam logic [7:0] DIV_LAST = 8'(SCAN_DIV - 1);
  localparam logic [3:0] DEB_MAX  = 4'(DEBOUNCE);

  logic [7:0]  div_reg;
  logic [1:0]  col_reg;
  logic [15:0] frame_reg;
  logic [15:0] prev_reg;
  logic [3:0]  cnt_reg;
  logic [15:0] keys_reg;
  logic        changed_reg;

  logic [3:0]  row_use;
  logic [3:0]  pressed;
  logic [15:0] frame_full;
  logic        terminal;
  logic        sample;
  logic        frame_done;
  logic [3:0]  cnt_next;
  logic        load;

`ifdef KEYSCAN_SYNC_EN
  logic [3:0] sync1_reg;
  logic [3:0] sync2_reg;

  // Two-stage synchronizer on the raw rows; rows idle high (no key pressed).
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_reg <= 4'b1111;
      sync2_reg <= 4'b1111;
    end else begin
      sync1_reg <= row_in;
      sync2_reg <= sync1_reg;
    end
  end

  assign row_use = sync2_reg;
`else
  assign row_use = row_in;
`endif

  assign pressed    = ~row_use;
  assign terminal   = (div_reg == DIV_LAST);
  assign sample     = scan_en && terminal;
  assign frame_done = sample && (col_reg == 2'd3);

  // The frame as it will look after this sample. Bit 15-k holds key k, which
  // sits at row k/4 and column k%4. Only the active column's bits are replaced.
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_bit
      localparam int         KEY = 15 - gi;
      localparam int         ROW = KEY / 4;
      localparam logic [1:0] COL = 2'(KEY % 4);
      assign frame_full[gi] = (col_reg == COL) ? pressed[ROW] : frame_reg[gi];
    end
  endgenerate

  // Stable-frame counter: count repeats up to DEBOUNCE, restart at 1 on any difference.
  always_comb begin
    cnt_next = 4'd1;
    if (frame_full == prev_reg) begin
      cnt_next = (cnt_reg == DEB_MAX) ? cnt_reg : cnt_reg + 4'd1;
    end
  end

  assign load = frame_done && (cnt_next == DEB_MAX) && (frame_full != keys_reg);

  // Active-low one-hot column strobe; all columns released while frozen.
  always_comb begin
    col_out = 4'b1111;
    if (scan_en) begin
      col_out[col_reg] = 1'b0;
    end
  end

  // Scan sequencing, frame capture, debounce history and published key map.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      div_reg     <= 8'd0;
      col_reg     <= 2'd0;
      frame_reg   <= 16'h0000;
      prev_reg    <= 16'h0000;
      cnt_reg     <= 4'd0;
      keys_reg    <= 16'h0000;
      changed_reg <= 1'b0;
    end else begin
      changed_reg <= load;
      if (scan_en) begin
        div_reg <= terminal ? 8'd0 : div_reg + 8'd1;
      end
      if (sample) begin
        col_reg   <= col_reg + 2'd1;
        frame_reg <= frame_full;
      end
      if (frame_done) begin
        prev_reg <= frame_full;
        cnt_reg  <= cnt_next;
      end
      if (load) begin
        keys_reg <= frame_full;
      end
    end
  end

  assign keys    = keys_reg;
  assign changed = changed_reg;

endmodule

// File: tb/tb_keyscan.sv
// tb_keyscan: directed bench for keyscan (SCAN_DIV=4, DEBOUNCE=3).
// A small keypad model pulls row r low while key (r,c) is held and column c
// is strobed. Edges are counted from reset release, and expected values are
// hand-computed.
module tb_keyscan;

  logic        clock;
  logic        reset;
  logic        scan_en;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic [15:0] keys;
  logic        changed;

  logic [15:0] pressed;
  int          cyc;
  int          pulses;
  int          errors;
  int          checks;

  keyscan #(.SCAN_DIV(4), .DEBOUNCE(3)) dut (
    .clock   (clock),
    .reset   (reset),
    .scan_en (scan_en),
    .row_in  (row_in),
    .col_out (col_out),
    .keys    (keys),
    .changed (changed)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Keypad: key k = 4*r + c connects row r to column c when held.
  always_comb begin
    row_in = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pressed[4*r + c] && !col_out[c]) row_in[r] = 1'b0;
      end
    end
  end

  // Advance to edge n after reset release, sampling 1 ns after each edge.
  task automatic tick_to(input int n);
    while (cyc < n) begin
      @(posedge clock);
      #1;
      cyc++;
      if (changed) pulses++;
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    cyc     = 0;
    pulses  = 0;
    reset   = 1'b0;
    scan_en = 1'b1;
    pressed = 16'h0000;
    pressed[5] = 1'b1;

    // Reset state while clocking.
    repeat (3) @(posedge clock);
    #1;
    chk("rst_col", {12'h0, col_out}, 16'h000E);
    chk("rst_keys", keys, 16'h0000);
    chk("rst_changed", {15'h0, changed}, 16'h0000);

    @(negedge clock);
    reset = 1'b1;

    // Column stepping every 4 cycles.
    tick_to(3);  chk("col_e3", {12'h0, col_out}, 16'h000E);
    tick_to(4);  chk("col_e4", {12'h0, col_out}, 16'h000D);
    tick_to(8);  chk("col_e8", {12'h0, col_out}, 16'h000B);
    tick_to(12); chk("col_e12", {12'h0, col_out}, 16'h0007);
    tick_to(16); chk("col_e16", {12'h0, col_out}, 16'h000E);

    // Key 5 held from release: published at end of frame 3.
    tick_to(47); chk("k5_pre_keys", keys, 16'h0000);
    tick_to(48);
    chk("k5_keys", keys, 16'h0400);
    chk("k5_changed", {15'h0, changed}, 16'h0001);
    chk("k5_pulses", 16'(pulses), 16'd1);
    tick_to(49); chk("k5_changed_drop", {15'h0, changed}, 16'h0000);

    // Release key 5: clears three frames later.
    tick_to(50);
    pressed[5] = 1'b0;
    tick_to(95); chk("rel_pre_keys", keys, 16'h0400);
    tick_to(96);
    chk("rel_keys", keys, 16'h0000);
    chk("rel_changed", {15'h0, changed}, 16'h0001);
    chk("rel_pulses", 16'(pulses), 16'd2);

    // Bounce: key 0 pressed, dropped across frame 2's column-0 sample, then held.
    pressed[0] = 1'b1;
    tick_to(113);
    pressed[0] = 1'b0;
    tick_to(117);
    pressed[0] = 1'b1;
    tick_to(160); chk("bnc_mid_keys", keys, 16'h0000);
    tick_to(175);
    chk("bnc_pre_keys", keys, 16'h0000);
    chk("bnc_pre_pulses", 16'(pulses), 16'd2);
    tick_to(176);
    chk("bnc_keys", keys, 16'h8000);
    chk("bnc_changed", {15'h0, changed}, 16'h0001);

    // Multi-key: add key 15 while key 0 stays held.
    pressed[15] = 1'b1;
    tick_to(223); chk("multi_pre_keys", keys, 16'h8000);
    tick_to(224);
    chk("multi_keys", keys, 16'h8001);
    chk("multi_pulses", 16'(pulses), 16'd4);

    // Freeze mid-column (column 1, divider at 2) for 20 cycles.
    tick_to(230);
    scan_en = 1'b0;
    #1;
    chk("frz_col", {12'h0, col_out}, 16'h000F);
    pressed = 16'h0000;
    tick_to(250);
    chk("frz_col_end", {12'h0, col_out}, 16'h000F);
    chk("frz_keys", keys, 16'h8001);
    chk("frz_changed", {15'h0, changed}, 16'h0000);
    chk("frz_pulses", 16'(pulses), 16'd4);
    scan_en = 1'b1;
    #1;
    chk("res_col", {12'h0, col_out}, 16'h000D);
    tick_to(251); chk("res_col_e1", {12'h0, col_out}, 16'h000D);
    tick_to(252); chk("res_col_e2", {12'h0, col_out}, 16'h000B);

    // Asynchronous reset mid-frame.
    tick_to(260);
    reset = 1'b0;
    #1;
    chk("arst_keys", keys, 16'h0000);
    chk("arst_changed", {15'h0, changed}, 16'h0000);
    chk("arst_col", {12'h0, col_out}, 16'h000E);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
